// File: rtl/rpsc_pkg.sv
// Shared types and helpers for the RPSC RF-permit interlock latch.
// FSM state encoding, illegal-state recovery target and priority encoder.
package rpsc_pkg;

  typedef enum logic [1:0] {
    PERMIT  = 2'd0,
    TRIPPED = 2'd1,
    RESTORE = 2'd2
  } rpsc_state_e;

  // The unused code 3 is treated as corrupted state and forced to the fail-safe state.
  localparam rpsc_state_e RECOVERY_STATE = TRIPPED;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [4:0] lowest_set_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rpsc_debounce.sv
// One fault channel: two-flop synchroniser followed by a run-length debouncer.
// The debounced bit only moves after DEBOUNCE consecutive samples disagreeing with it.
module rpsc_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_deb
);

  logic       sync_q1;
  logic       sync_q2;
  logic [7:0] run_cnt;
  logic       deb_q;

  // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= i_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= 8'd0;
      deb_q   <= 1'b0;
    end else if (sync_q2 == deb_q) begin
      run_cnt <= 8'd0;
    end else if (run_cnt == 8'(DEBOUNCE - 1)) begin
      run_cnt <= 8'd0;
      deb_q   <= sync_q2;
    end else begin
      run_cnt <= run_cnt + 8'd1;
    end
  end

  assign o_deb = deb_q;

endmodule

// File: rtl/rpsc_interlock_latch.sv
// RF-permit interlock: debounced fault channels, sticky fault latch, first-cause record
// and ack + timed restore. Define RPSC_TRIP_COUNT_EN to build the saturating trip counter.
module rpsc_interlock_latch
  import rpsc_pkg::*;
#(
  parameter int N_FAULT     = 8,
  parameter int DEBOUNCE    = 4,
  parameter int RESTORE_CYC = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_FAULT-1:0]         i_fault,
  input  logic [N_FAULT-1:0]         i_mask,
  input  logic                       i_ack,
  output logic                       o_Not_RF_PERM,
  output logic                       o_Not_Alarm,
  output logic [N_FAULT-1:0]         o_fault_latched,
  output logic [$clog2(N_FAULT)-1:0] o_first_fault,
  output logic                       o_first_valid,
  output logic [1:0]                 o_state,
  output logic [15:0]                o_trip_count
);

  localparam int FW = $clog2(N_FAULT);
  localparam int RW = ($clog2(RESTORE_CYC) < 1) ? 1 : $clog2(RESTORE_CYC);

  logic [1:0]         rst_sync;
  logic               rst_int;
  logic [N_FAULT-1:0] deb;
  logic [N_FAULT-1:0] f;
  logic               any_f;

  rpsc_state_e        state;
  logic [N_FAULT-1:0] latched;
  logic [FW-1:0]      first_idx;
  logic               first_valid;
  logic [RW-1:0]      restore_cnt;

  // Assert asynchronously, release only after two clean edges so no flop sees a runt release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  for (genvar i = 0; i < N_FAULT; i++) begin : g_ch
    rpsc_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk   (clk),
      .rst   (rst_int),
      .i_raw (i_fault[i]),
      .o_deb (deb[i])
    );
  end

  assign f     = deb & ~i_mask;
  assign any_f = |f;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state       <= TRIPPED;
      latched     <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
      restore_cnt <= '0;
    end else begin
      case (state)
        PERMIT: begin
          if (any_f) begin
            state       <= TRIPPED;
            latched     <= latched | f;
            first_idx   <= FW'(lowest_set_index(32'(f)));
            first_valid <= 1'b1;
          end
        end
        TRIPPED: begin
          latched <= latched | f;
          if (i_ack && !any_f) begin
            state       <= RESTORE;
            restore_cnt <= '0;
          end
        end
        RESTORE: begin
          if (any_f) begin
            state   <= TRIPPED;
            latched <= latched | f;
            if (!first_valid) begin
              first_idx   <= FW'(lowest_set_index(32'(f)));
              first_valid <= 1'b1;
            end
          end else if (restore_cnt == RW'(RESTORE_CYC - 1)) begin
            state       <= PERMIT;
            latched     <= '0;
            first_idx   <= '0;
            first_valid <= 1'b0;
          end else begin
            restore_cnt <= restore_cnt + 1'b1;
          end
        end
        default: state <= RECOVERY_STATE;
      endcase
    end
  end

`ifdef RPSC_TRIP_COUNT_EN
  logic [15:0] trip_cnt;
  logic        trip_event;

  assign trip_event = any_f && (state == PERMIT || state == RESTORE);

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int)                                  trip_cnt <= 16'd0;
    else if (trip_event && trip_cnt != 16'hFFFF)  trip_cnt <= trip_cnt + 16'd1;
  end
  assign o_trip_count = trip_cnt;
`else
  assign o_trip_count = 16'h0;
`endif

  // Permit is decoded only from the state register, never from the fault inputs.
  assign o_Not_RF_PERM   = (state != PERMIT);
  assign o_Not_Alarm     = ~|latched;
  assign o_fault_latched = latched;
  assign o_first_fault   = first_idx;
  assign o_first_valid   = first_valid;
  assign o_state         = state;

endmodule

// File: tb/tb_rpsc_interlock_latch.sv
// Directed bench for rpsc_interlock_latch (N_FAULT=8, DEBOUNCE=4, RESTORE_CYC=10).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rpsc_interlock_latch;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] i_fault;
  logic [N-1:0] i_mask;
  logic         i_ack;
  logic         o_Not_RF_PERM;
  logic         o_Not_Alarm;
  logic [N-1:0] o_fault_latched;
  logic [2:0]   o_first_fault;
  logic         o_first_valid;
  logic [1:0]   o_state;
  logic [15:0]  o_trip_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_trips = 0;

`ifdef RPSC_TRIP_COUNT_EN
  localparam bit TC_EN = 1'b1;
`else
  localparam bit TC_EN = 1'b0;
`endif

  rpsc_interlock_latch #(.N_FAULT(N), .DEBOUNCE(4), .RESTORE_CYC(10)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_fault         (i_fault),
    .i_mask          (i_mask),
    .i_ack           (i_ack),
    .o_Not_RF_PERM   (o_Not_RF_PERM),
    .o_Not_Alarm     (o_Not_Alarm),
    .o_fault_latched (o_fault_latched),
    .o_first_fault   (o_first_fault),
    .o_first_valid   (o_first_valid),
    .o_state         (o_state),
    .o_trip_count    (o_trip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic note_trip();
    if (TC_EN) exp_trips++;
  endtask

  // Pulse ack for one edge; the edge that samples it enters RESTORE.
  task automatic pulse_ack();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    i_fault = '0;
    i_mask  = '0;
    i_ack   = 1'b0;
    tick(3);
    check("rst_state",   32'(o_state), 32'd1);
    check("rst_perm",    32'(o_Not_RF_PERM), 32'd1);
    check("rst_alarm",   32'(o_Not_Alarm), 32'd1);
    check("rst_latch",   32'(o_fault_latched), 32'h0);
    check("rst_valid",   32'(o_first_valid), 32'd0);
    check("rst_trips",   32'(o_trip_count), 32'd0);
    reset = 1'b0;
    tick(5);

    // 1: ack with no faults -> 10 cycles of RESTORE then PERMIT
    pulse_ack();
    check("t1_restore", 32'(o_state), 32'd2);
    tick(9);
    check("t1_hold",    32'(o_Not_RF_PERM), 32'd1);
    tick();
    check("t1_perm",    32'(o_Not_RF_PERM), 32'd0);
    check("t1_state",   32'(o_state), 32'd0);
    check("t1_alarm",   32'(o_Not_Alarm), 32'd1);

    // 2: three-cycle glitch is rejected
    i_fault[3] = 1'b1;
    tick(3);
    i_fault[3] = 1'b0;
    tick(10);
    check("t2_perm",  32'(o_Not_RF_PERM), 32'd0);
    check("t2_latch", 32'(o_fault_latched), 32'h0);

    // 3: held fault trips on exactly the 7th edge
    i_fault[3] = 1'b1;
    tick(6);
    check("t3_pre",   32'(o_Not_RF_PERM), 32'd0);
    tick();
    note_trip();
    check("t3_perm",  32'(o_Not_RF_PERM), 32'd1);
    check("t3_latch", 32'(o_fault_latched), 32'h08);
    check("t3_first", 32'(o_first_fault), 32'd3);
    check("t3_valid", 32'(o_first_valid), 32'd1);
    check("t3_alarm", 32'(o_Not_Alarm), 32'd0);
    check("t3_trips", 32'(o_trip_count), 32'(exp_trips));

    // back to PERMIT, latches cleared
    i_fault = '0;
    tick(8);
    pulse_ack();
    tick(10);
    check("t4_clr_state", 32'(o_state), 32'd0);
    check("t4_clr_latch", 32'(o_fault_latched), 32'h0);
    check("t4_clr_valid", 32'(o_first_valid), 32'd0);

    // 4: simultaneous faults on channels 5 and 2
    i_fault = 8'h24;
    tick(7);
    note_trip();
    check("t4_perm",  32'(o_Not_RF_PERM), 32'd1);
    check("t4_first", 32'(o_first_fault), 32'd2);
    check("t4_latch", 32'(o_fault_latched), 32'h24);

    // 5a: ack ignored while fault active
    pulse_ack();
    tick();
    check("t5_ack_ign", 32'(o_state), 32'd1);

    // 5b: clear, ack, fault[6] arrives 5 cycles into RESTORE
    i_fault = '0;
    tick(8);
    i_fault[6] = 1'b1;
    pulse_ack();
    check("t5_restore", 32'(o_state), 32'd2);
    tick(5);
    check("t5_still",   32'(o_state), 32'd2);
    tick();
    note_trip();
    check("t5_retrip",  32'(o_state), 32'd1);
    check("t5_first",   32'(o_first_fault), 32'd2);
    check("t5_latch",   32'(o_fault_latched), 32'h64);
    check("t5_trips",   32'(o_trip_count), 32'(exp_trips));

    // 6: masked channel does not trip; unmasking trips on the next edge
    i_fault = '0;
    tick(8);
    pulse_ack();
    tick(10);
    check("t6_permit", 32'(o_state), 32'd0);
    i_mask[1]  = 1'b1;
    i_fault[1] = 1'b1;
    tick(10);
    check("t6_masked", 32'(o_Not_RF_PERM), 32'd0);
    check("t6_mlatch", 32'(o_fault_latched), 32'h0);
    i_mask = '0;
    tick();
    note_trip();
    check("t6_trip",   32'(o_state), 32'd1);
    check("t6_latch",  32'(o_fault_latched), 32'h02);
    check("t6_first",  32'(o_first_fault), 32'd1);
    check("t6_trips",  32'(o_trip_count), 32'(exp_trips));

    // reset mid-operation clears everything and lands in TRIPPED immediately
    reset = 1'b1;
    #1;
    check("rst2_state", 32'(o_state), 32'd1);
    check("rst2_latch", 32'(o_fault_latched), 32'h0);
    check("rst2_trips", 32'(o_trip_count), 32'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rpsc_interlock_latch.md
Name: rpsc_interlock_latch

Overview:
- Parametrised successor to the RPSC RF-permit card logic.
- Takes N active-high fault lines (the Not_*_OK / FF* family), debounces each one, and drops RF permit on any unmasked fault.
- Latches which faults occurred and which came first; RF permit returns only after operator acknowledge plus a timed restore hold.
- Sits between the card-level fault inputs and the RF drive permit / alarm outputs.

Parameters:
- N_FAULT, 8, number of fault channels (2..32).
- DEBOUNCE, 4, consecutive identical samples needed to change a debounced channel (1..255).
- RESTORE_CYC, 1000, clock cycles in RESTORE before permit returns (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_fault  in  N_FAULT  raw fault lines, 1 = fault; asynchronous to clk, each double-flop synchronised.
- i_mask  in  N_FAULT  1 = channel ignored for trip and latch.
- i_ack  in  1  operator acknowledge, level-sampled.
- o_Not_RF_PERM  out  1  0 = RF permitted.
- o_Not_Alarm  out  1  0 = at least one latched fault.
- o_fault_latched  out  N_FAULT  sticky fault record.
- o_first_fault  out  $clog2(N_FAULT)  index of the first trip cause.
- o_first_valid  out  1  o_first_fault is meaningful.
- o_state  out  2  current FSM state encoding.
- o_trip_count  out  16  trip counter; see Optional Feature.

Behaviour:
- Reset (async assert; release synchronised in the block):
  - State = TRIPPED (fail-safe); o_Not_RF_PERM=1; o_Not_Alarm=1.
  - o_fault_latched=0, o_first_fault=0, o_first_valid=0, o_trip_count=0.
  - Debounce counters = 0; debounced outputs = 0.
- Debounce (per channel, after the 2-flop synchroniser):
  - The registered debounced bit d[i] flips only after DEBOUNCE consecutive synchronised samples that differ from the current d[i].
  - Any sample equal to d[i] resets the counter.
- Effective fault: f[i] = d[i] & ~i_mask[i]. any_f = |f.
- FSM states: PERMIT=0, TRIPPED=1, RESTORE=2; code 3 is illegal and recovers to TRIPPED.
- PERMIT:
  - Outputs: o_Not_RF_PERM=0.
  - Transition: any_f -> TRIPPED.
  - On that edge: o_fault_latched |= f; o_first_fault = lowest set index of f; o_first_valid=1.
- TRIPPED:
  - Outputs: o_Not_RF_PERM=1.
  - Every cycle: o_fault_latched |= f.
  - i_ack=1 & ~any_f -> RESTORE and restore counter loaded to 0.
  - i_ack while any_f=1 is ignored.
- RESTORE:
  - Outputs: o_Not_RF_PERM=1.
  - Counter increments each cycle.
  - any_f -> TRIPPED. Latch |= f. first_fault is unchanged if o_first_valid is already 1.
  - Counter reaches RESTORE_CYC-1 with ~any_f -> PERMIT. On that edge clear o_fault_latched, o_first_valid and o_first_fault.
- Output decode:
  - o_Not_RF_PERM is decoded from the registered state; no combinational path from i_fault.
  - o_Not_Alarm = ~|o_fault_latched.
- Latency: a raw fault edge reaches o_Not_RF_PERM=1 after 2 (sync) + DEBOUNCE + 1 clock edges.
- Simultaneous faults in one cycle: all are latched; the lowest index wins first_fault.
- Mask changes:
  - Changing i_mask never clears latches.
  - Unmasking a channel whose d[i] is already 1 trips on the next edge.
- Reset mid-RESTORE or mid-PERMIT: returns immediately to TRIPPED with latches cleared.

Optional Feature:
- Macro: RPSC_TRIP_COUNT_EN.
- Defined: o_trip_count increments on every PERMIT->TRIPPED and RESTORE->TRIPPED transition. It saturates at 16'hFFFF, is cleared only by reset, and is not cleared by ack.
- Undefined: o_trip_count is tied to 16'h0 and no counter logic is present.

Decomposition:
- rpsc_pkg:
  - rpsc_state_e enum (PERMIT, TRIPPED, RESTORE).
  - Localparam for the illegal-state recovery target.
  - Function lowest_set_index.
- Sub-module rpsc_debounce:
  - One channel: synchroniser, counter and debounced register.
  - DEBOUNCE parameter.
  - Instantiated N_FAULT times in a generate loop.

Test Plan (N_FAULT=8, DEBOUNCE=4, RESTORE_CYC=10):
1. Reset released, no faults:
   - Stimulus: pulse i_ack for 1 cycle.
   - Expect: o_Not_RF_PERM=1 for 10 cycles, then 0; o_state=0; o_Not_Alarm=1.
2. Glitch rejection:
   - Stimulus: i_fault[3]=1 for 3 cycles, then 0.
   - Expect: no trip; o_Not_RF_PERM stays 0.
3. Held fault:
   - Stimulus: i_fault[3] held.
   - Expect: o_Not_RF_PERM=1 exactly 7 edges after assertion; o_fault_latched=8'h08; o_first_fault=3; o_Not_Alarm=0.
4. Simultaneous faults:
   - Stimulus: i_fault[5] and i_fault[2] rise on the same cycle.
   - Expect: o_first_fault=2; o_fault_latched=8'h24.
5. Ack while fault active, then re-trip in RESTORE:
   - Stimulus: i_ack while fault still asserted.
   - Expect: stays TRIPPED.
   - Stimulus: clear the fault, ack, then a new fault[6] 5 cycles into RESTORE.
   - Expect: back to TRIPPED; first_fault unchanged; latch bit 6 set.
6. Mask and trip counter:
   - Stimulus: i_mask[1]=1 with i_fault[1] held.
   - Expect: no trip.
   - Stimulus: unmask.
   - Expect: trip next edge; with RPSC_TRIP_COUNT_EN, o_trip_count increments by 1; without, o_trip_count=0.
